// File: rtl/sp_ram_arbiter_pkg.sv
// Shared types and constants for the instr/data single-port RAM arbiter.
package sp_ram_arb_pkg;

  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_e;

  localparam int          STARVE_W   = 4;
  localparam logic [31:0] RDATA_IDLE = 32'h0;

endpackage

// File: rtl/sp_ram_arbiter_if.sv
// Bundles the fetch port, data port and RAM port seen by sp_ram_arbiter.
interface sp_ram_arbiter_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  instr_req_i;
  logic                  instr_gnt_o;
  logic [ADDR_WIDTH-1:0] instr_addr_i;
  logic                  instr_rvalid_o;
  logic [31:0]           instr_rdata_o;

  logic                  data_req_i;
  logic                  data_gnt_o;
  logic [ADDR_WIDTH-1:0] data_addr_i;
  logic                  data_we_i;
  logic [3:0]            data_be_i;
  logic [31:0]           data_wdata_i;
  logic                  data_rvalid_o;
  logic [31:0]           data_rdata_o;

  logic                  ram_en_o;
  logic [ADDR_WIDTH-1:0] ram_addr_o;
  logic                  ram_we_o;
  logic [3:0]            ram_be_o;
  logic [31:0]           ram_wdata_o;
  logic [31:0]           ram_rdata_i;

  modport slave (
    input  instr_req_i, instr_addr_i,
    input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    input  ram_rdata_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    output data_gnt_o, data_rvalid_o, data_rdata_o,
    output ram_en_o, ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o
  );

  modport master (
    output instr_req_i, instr_addr_i,
    output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    output ram_rdata_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    input  data_gnt_o, data_rvalid_o, data_rdata_o,
    input  ram_en_o, ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o
  );
endinterface

// File: rtl/sp_ram_arbiter_prio.sv
// Grant decision for sp_ram_arbiter. SP_RAM_ARB_RR_EN selects round-robin;
// otherwise fixed data priority with an instr starvation guard.
module sp_ram_arb_prio
  import sp_ram_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                i_block,
  input  logic                i_instr_req,
  input  logic                i_data_req,
`ifdef SP_RAM_ARB_RR_EN
  input  owner_e              i_last,
  output owner_e              o_last_nxt,
`else
  input  logic [STARVE_W-1:0] i_starve_cnt,
  output logic [STARVE_W-1:0] o_starve_cnt_nxt,
`endif
  output logic [1:0]          o_gnt
);

`ifdef SP_RAM_ARB_RR_EN
  always_comb begin
    o_gnt      = '0;
    o_last_nxt = i_last;
    if (!i_block) begin
      if (i_instr_req && i_data_req) begin
        o_gnt = (i_last == OWNER_DATA) ? 2'b01 : 2'b10;
      end else if (i_instr_req) begin
        o_gnt = 2'b01;
      end else if (i_data_req) begin
        o_gnt = 2'b10;
      end
    end
    if (o_gnt[0]) o_last_nxt = OWNER_INSTR;
    if (o_gnt[1]) o_last_nxt = OWNER_DATA;
  end
`else
  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic w_instr_first;

  always_comb begin
    o_gnt            = '0;
    o_starve_cnt_nxt = i_starve_cnt;
    w_instr_first    = (i_starve_cnt >= LIMIT);
    if (!i_block) begin
      if (i_instr_req && (!i_data_req || w_instr_first)) begin
        o_gnt = 2'b01;
      end else if (i_data_req) begin
        o_gnt = 2'b10;
      end
    end
    // Counter saturates at the limit instead of wrapping.
    if (!i_instr_req || o_gnt[0]) begin
      o_starve_cnt_nxt = '0;
    end else if (i_starve_cnt < LIMIT) begin
      o_starve_cnt_nxt = i_starve_cnt + STARVE_W'(1);
    end
  end
`endif

endmodule

// File: rtl/sp_ram_arbiter.sv
// Shares one single-port RAM between instr fetch and data ports.
// Define SP_RAM_ARB_RR_EN for round-robin instead of data priority.
module sp_ram_arbiter
  import sp_ram_arb_pkg::*;
#(
  parameter int          ADDR_WIDTH   = 12,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  sp_ram_arbiter_if.slave  bus
);

  logic [1:0]            w_gnt;
  logic [ADDR_WIDTH-1:0] w_ram_addr;
  logic                  w_rsp;
  logic                  w_instr_rvalid;
  logic                  w_data_rvalid;
  logic                  r_valid;
  logic                  r_wr;
  owner_e                r_owner;

`ifdef SP_RAM_ARB_RR_EN
  owner_e                r_last;
  owner_e                w_last_nxt;
`else
  logic [STARVE_W-1:0]   r_starve_cnt;
  logic [STARVE_W-1:0]   w_starve_nxt;
`endif

  sp_ram_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .i_block          (rst_i),
    .i_instr_req      (bus.instr_req_i),
    .i_data_req       (bus.data_req_i),
`ifdef SP_RAM_ARB_RR_EN
    .i_last           (r_last),
    .o_last_nxt       (w_last_nxt),
`else
    .i_starve_cnt     (r_starve_cnt),
    .o_starve_cnt_nxt (w_starve_nxt),
`endif
    .o_gnt            (w_gnt)
  );

  assign bus.instr_gnt_o = w_gnt[0];
  assign bus.data_gnt_o  = w_gnt[1];

  always_comb begin
    bus.ram_en_o    = 1'b0;
    w_ram_addr      = '0;
    bus.ram_we_o    = 1'b0;
    bus.ram_be_o    = '0;
    bus.ram_wdata_o = '0;
    if (w_gnt[1]) begin
      bus.ram_en_o    = 1'b1;
      w_ram_addr      = bus.data_addr_i;
      bus.ram_we_o    = bus.data_we_i;
      bus.ram_be_o    = bus.data_be_i;
      bus.ram_wdata_o = bus.data_wdata_i;
    end else if (w_gnt[0]) begin
      bus.ram_en_o = 1'b1;
      w_ram_addr   = bus.instr_addr_i;
      bus.ram_be_o = 4'hF;
    end
  end

  assign bus.ram_addr_o = w_ram_addr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid      <= 1'b0;
      r_wr         <= 1'b0;
      r_owner      <= OWNER_INSTR;
`ifdef SP_RAM_ARB_RR_EN
      r_last       <= OWNER_INSTR;
`else
      r_starve_cnt <= '0;
`endif
    end else begin
      r_valid <= |w_gnt;
      if (|w_gnt) begin
        r_owner <= w_gnt[1] ? OWNER_DATA : OWNER_INSTR;
        r_wr    <= w_gnt[1] & bus.data_we_i;
      end
`ifdef SP_RAM_ARB_RR_EN
      r_last       <= w_last_nxt;
`else
      r_starve_cnt <= w_starve_nxt;
`endif
    end
  end

  // Gating with rst_i drops a response that falls into the first reset cycle.
  assign w_rsp          = r_valid & ~rst_i;
  assign w_instr_rvalid = w_rsp && (r_owner == OWNER_INSTR);
  assign w_data_rvalid  = w_rsp && (r_owner == OWNER_DATA);

  assign bus.instr_rvalid_o = w_instr_rvalid;
  assign bus.data_rvalid_o  = w_data_rvalid;
  assign bus.instr_rdata_o  = w_instr_rvalid ? bus.ram_rdata_i : RDATA_IDLE;
  assign bus.data_rdata_o   = (w_data_rvalid && !r_wr) ? bus.ram_rdata_i : RDATA_IDLE;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Scoreboard bench for sp_ram_arbiter with a behavioural RAM and policy model.
module tb_sp_ram_arbiter;
  localparam int          AW    = 12;
  localparam int unsigned LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sp_ram_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

  sp_ram_arbiter #(
    .ADDR_WIDTH  (AW),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Behavioural RAM attached to the DUT's RAM port.
  logic [31:0] mem [1024];
  logic [31:0] ram_q;
  assign bus.ram_rdata_i = ram_q;
  always @(posedge clk) begin
    if (bus.ram_en_o) begin
      if (bus.ram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (bus.ram_be_o[b]) mem[bus.ram_addr_o[11:2]][8*b +: 8] = bus.ram_wdata_o[8*b +: 8];
      end else begin
        ram_q <= mem[bus.ram_addr_o[11:2]];
      end
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [1024];
  int unsigned waited;
  int          last_win;   // 1 = instr, 2 = data

  typedef struct {
    int unsigned cyc;
    bit          port;     // 0 instr, 1 data
    logic [31:0] data;
  } exp_t;
  exp_t q[$];

  int unsigned cyc = 0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a response.
  bit   due;
  exp_t e;
  always @(negedge clk) begin
    due = (q.size() > 0) && (q[0].cyc == cyc - 1);
    if (bus.instr_rvalid_o && bus.data_rvalid_o) chk("rvalid_onehot", 32'd2, 32'd1);
    if (bus.instr_rvalid_o || bus.data_rvalid_o) begin
      if (!due) begin
        chk("unexpected_rvalid", {30'd0, bus.data_rvalid_o, bus.instr_rvalid_o}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("rsp_port", {31'd0, bus.data_rvalid_o}, {31'd0, e.port});
        chk("rsp_data", e.port ? bus.data_rdata_o : bus.instr_rdata_o, e.data);
      end
    end else if (due) begin
      e = q.pop_front();
      chk("missing_rvalid", 32'd0, {31'd0, e.port} + 32'd1);
    end
    if (!bus.instr_rvalid_o) chk("instr_rdata_idle", bus.instr_rdata_o, 32'h0);
    if (!bus.data_rvalid_o)  chk("data_rdata_idle", bus.data_rdata_o, 32'h0);
  end

  task automatic cycle(input bit r, input bit ireq, input logic [AW-1:0] iaddr,
                       input bit dreq, input logic [AW-1:0] daddr, input bit dwe,
                       input logic [3:0] dbe, input logic [31:0] dwd);
    int          win;
    logic [31:0] rd;
    @(posedge clk);
    #1;
    rst              = r;
    bus.instr_req_i  = ireq;
    bus.instr_addr_i = iaddr;
    bus.data_req_i   = dreq;
    bus.data_addr_i  = daddr;
    bus.data_we_i    = dwe;
    bus.data_be_i    = dbe;
    bus.data_wdata_i = dwd;
    if (r && q.size() > 0 && q[q.size()-1].cyc == cyc - 1) void'(q.pop_back());

    win = 0;
    if (!r) begin
      if (ireq && dreq) begin
`ifdef SP_RAM_ARB_RR_EN
        win = (last_win == 2) ? 1 : 2;
`else
        win = (waited >= LIMIT) ? 1 : 2;
`endif
      end else if (ireq) win = 1;
      else if (dreq) win = 2;
    end

    @(negedge clk);
    chk("instr_gnt", {31'd0, bus.instr_gnt_o}, {31'd0, win == 1});
    chk("data_gnt",  {31'd0, bus.data_gnt_o},  {31'd0, win == 2});
    chk("ram_en",    {31'd0, bus.ram_en_o},    {31'd0, win != 0});
    chk("ram_addr",  {20'd0, bus.ram_addr_o},  (win == 1) ? {20'd0, iaddr} : (win == 2) ? {20'd0, daddr} : 32'd0);
    chk("ram_we",    {31'd0, bus.ram_we_o},    {31'd0, win == 2 && dwe});
    chk("ram_be",    {28'd0, bus.ram_be_o},    (win == 1) ? 32'hF : (win == 2) ? {28'd0, dbe} : 32'd0);
    chk("ram_wdata", bus.ram_wdata_o,          (win == 2) ? dwd : 32'd0);

    if (win == 1) begin
      q.push_back('{cyc: cyc, port: 1'b0, data: ref_mem[iaddr[11:2]]});
    end else if (win == 2) begin
      rd = ref_mem[daddr[11:2]];
      if (dwe) begin
        for (int b = 0; b < 4; b++)
          if (dbe[b]) ref_mem[daddr[11:2]][8*b +: 8] = dwd[8*b +: 8];
        rd = 32'h0;
      end
      q.push_back('{cyc: cyc, port: 1'b1, data: rd});
    end

    if (r) begin
      waited   = 0;
      last_win = 1;
    end else begin
      if (win != 0) last_win = win;
      if (!ireq || win == 1) waited = 0;
      else if (waited < LIMIT) waited++;
    end
  endtask

  task automatic idle(input bit r);
    cycle(r, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    logic [31:0] seed;
    rst              = 1'b1;
    bus.instr_req_i  = 1'b0;
    bus.instr_addr_i = '0;
    bus.data_req_i   = 1'b0;
    bus.data_addr_i  = '0;
    bus.data_we_i    = 1'b0;
    bus.data_be_i    = '0;
    bus.data_wdata_i = '0;
    waited   = 0;
    last_win = 1;
    seed     = $urandom;
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = seed ^ (i * 32'h9E3779B1);
      ref_mem[i] = seed ^ (i * 32'h9E3779B1);
    end

    // Reset with requests held high: no grants may appear.
    cycle(1'b1, 1'b1, 12'h004, 1'b1, 12'h008, 1'b0, 4'hF, 32'h0);
    idle(1'b1);

    // Instr-only fetch of 0x010.
    cycle(1'b0, 1'b1, 12'h010, 1'b0, '0, 1'b0, '0, '0);
    idle(1'b0);

    // Partial write then readback of 0x020.
    cycle(1'b0, 1'b0, '0, 1'b1, 12'h020, 1'b1, 4'b0101, 32'hDEADBEEF);
    cycle(1'b0, 1'b0, '0, 1'b1, 12'h020, 1'b0, 4'hF, 32'h0);
    idle(1'b0);

    // Continuous contention: policy pattern and response routing.
    for (int i = 0; i < 15; i++)
      cycle(1'b0, 1'b1, 12'(16 * i), 1'b1, 12'(16 * i + 8), 1'b0, 4'hF, 32'h0);
    idle(1'b0);

    // Reset in the cycle right after a data read grant.
    cycle(1'b0, 1'b0, '0, 1'b1, 12'h044, 1'b0, 4'hF, 32'h0);
    cycle(1'b1, 1'b1, 12'h048, 1'b1, 12'h04C, 1'b0, 4'hF, 32'h0);
    cycle(1'b1, 1'b1, 12'h048, 1'b1, 12'h04C, 1'b0, 4'hF, 32'h0);
    cycle(1'b0, 1'b0, '0, 1'b1, 12'h050, 1'b0, 4'hF, 32'h0);
    idle(1'b0);

    // Zero byte-enable write to 0x030, then readback.
    cycle(1'b0, 1'b0, '0, 1'b1, 12'h030, 1'b1, 4'h0, 32'hFFFFFFFF);
    cycle(1'b0, 1'b0, '0, 1'b1, 12'h030, 1'b0, 4'hF, 32'h0);
    idle(1'b0);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 63) == 0,
            $urandom_range(0, 3) != 0, 12'($urandom_range(0, 511)),
            $urandom_range(0, 3) != 0, 12'($urandom_range(0, 511)),
            $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), $urandom);
    end
    idle(1'b0);
    idle(1'b0);
    chk("scoreboard_drained", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sp_ram_arbiter.md
# sp_ram_arbiter

Shares one single-port byte-enabled testbench RAM (registered read, one-cycle latency, word-indexed by byte address >> 2) between the core's instruction-fetch port and data port. Both requesters use an OBI-style req/gnt/rvalid handshake. The block arbitrates every cycle, drives the RAM port from the winner, and routes the read response back to the requester that owns it. It sits in the core testbench between the core's fetch/LSU interfaces and the RAM instance.

## Interface
- ADDR_WIDTH, 12, byte-address width of both requesters and the RAM port.
- STARVE_LIMIT, 4, consecutive cycles instr_req may be denied before it is force-granted (1..15).
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- instr_req_i  in  1  fetch request.
- instr_gnt_o  out  1  fetch grant, same cycle.
- instr_addr_i  in  ADDR_WIDTH  fetch byte address.
- instr_rvalid_o  out  1  fetch response valid.
- instr_rdata_o  out  32  fetch read data.
- data_req_i  in  1  data request.
- data_gnt_o  out  1  data grant, same cycle.
- data_addr_i  in  ADDR_WIDTH  data byte address.
- data_we_i  in  1  write enable.
- data_be_i  in  4  byte enables.
- data_wdata_i  in  32  write data.
- data_rvalid_o  out  1  data response valid (reads and writes).
- data_rdata_o  out  32  data read data.
- ram_en_o  out  1  RAM access enable.
- ram_addr_o  out  ADDR_WIDTH  RAM byte address.
- ram_we_o  out  1  RAM write enable.
- ram_be_o  out  4  RAM byte enables.
- ram_wdata_o  out  32  RAM write data.
- ram_rdata_i  in  32  RAM read data, valid the cycle after ram_en_o.

## Operation
- Each cycle, at most one requester is granted. A grant occurs when the chosen req_i is high. gnt_o is combinational from req_i and arbiter state.
- Default policy is fixed priority, data over instr. A 4-bit starve counter increments on each cycle where instr_req_i=1 and instr is not granted. It clears on any instr grant or when instr_req_i=0. When the counter reaches STARVE_LIMIT, instr wins the next contended cycle.
- RAM port follows the winner combinationally: ram_en_o=1, with addr, we, be and wdata taken from the winner. The instr port always drives we=0, be=4'hF and wdata=0. With no grant: ram_en_o=0, and all other ram_* outputs are 0.
- Response tracking uses a registered owner flag and a registered valid flag. A grant sets valid and records the owner for the next cycle. The next cycle's rvalid_o is asserted only to that owner.
- rdata_o equals ram_rdata_i while that port's rvalid_o=1, and 0 otherwise.
- A data write returns rvalid with rdata=0.
- A write with be=4'h0 is still granted and returns rvalid; no bytes change.
- addr[1:0] passes through unmodified. Alignment is the RAM's responsibility.

## Timing
- Grant latency is 0 cycles. Response latency is exactly 1 cycle after the gnt cycle.
- Back-to-back grants are allowed every cycle, to either port, with no bubble.
- Simultaneous req: the policy decides. Exactly one gnt_o is high.
- Reset values: instr_gnt_o=0, data_gnt_o=0, both rvalid_o=0, both rdata_o=0, ram_en_o=0, starve counter=0, owner=instr, last-winner=instr.
- While rst_i=1, all gnt_o and ram_en_o are forced to 0.
- Reset mid-operation: a response due in the cycle after rst_i is asserted is dropped (rvalid stays 0). No grant is issued in any reset cycle.
- The starve counter saturates at STARVE_LIMIT and does not wrap.

## Configuration
- SP_RAM_ARB_RR_EN defined: round-robin arbitration. On contention, the port not granted last wins. The last-winner register updates on every grant. The starve counter logic is not compiled, and STARVE_LIMIT is ignored.
- SP_RAM_ARB_RR_EN undefined: fixed data priority with starvation guard, as described under Operation.

## Structure
- Package sp_ram_arb_pkg:
  - owner_e enum {OWNER_INSTR, OWNER_DATA}.
  - STARVE_W=4.
  - Constant RDATA_IDLE=32'h0.
- Sub-module sp_ram_arb_prio: takes the two req signals plus policy state, produces one-hot grant and next-state. It holds both the round-robin and fixed-priority variants under the macro.
- The top level holds the RAM mux, the response owner/valid registers and the output gating.

## Test plan
- Instr-only read of addr 0x010: instr_gnt_o=1 in the same cycle, ram_addr_o=0x010, ram_we_o=0; next cycle instr_rvalid_o=1 with instr_rdata_o = RAM word 4, and data_rvalid_o=0.
- Data write of 0xDEADBEEF to 0x020 with be=4'b0101, followed by a data read of 0x020: the write returns rvalid with rdata=0; the read returns 0x00AD00EF over the prior contents' bytes 1 and 3.
- Both ports requesting every cycle, fixed mode, STARVE_LIMIT=4: grants are data×4, then instr×1, repeating; each rvalid goes to the correct port one cycle later.
- Both ports requesting every cycle with SP_RAM_ARB_RR_EN defined: grants alternate data/instr starting with data (last-winner resets to instr).
- rst_i asserted in the cycle after a data read grant: data_rvalid_o stays 0, all gnt_o=0 during reset, and the first post-reset grant behaves normally.
- Data write with be=4'h0 to 0x030: granted, rvalid returned next cycle, RAM word 0x0C unchanged on readback.
